// File: rtl/gray_pkg.sv
// +--------------------------------------------------------------------------+
// | gray_pkg : shared constants and gray/binary helper functions              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package gray_pkg;

  localparam int GRAY_W_DEFAULT = 10;
  localparam int ERR_CNT_W      = 8;
  localparam int GRAY_MAX_W     = 32;

  typedef logic [GRAY_MAX_W-1:0] gword_t;

  // Leading zero bits do not disturb the prefix XOR, so narrower words are
  // handled by zero-extending into gword_t.
  function automatic gword_t gray2bin(input gword_t w);
    gword_t r;
    r = '0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      r[i] = ^(w >> i);
    end
    return r;
  endfunction

  function automatic gword_t bin2gray(input gword_t w);
    return w ^ (w >> 1);
  endfunction

  function automatic logic onehot_or_zero(input gword_t w);
    return (w & (w - 1)) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_gray2bin_stage.sv
// +--------------------------------------------------------------------------+
// | dec_gray2bin_stage : one register slice, resolves word bits HI..LO        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module dec_gray2bin_stage #(
  parameter int WIDTH = 10,
  parameter int HI    = 9,
  parameter int LO    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_err,
  output logic             valid,
  output logic [WIDTH-1:0] word,
  output logic             err
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dec;

  // Word bits above HI are already binary, bits below LO are still gray.
  always_comb begin : p_dec
    logic acc;
    acc = 1'b0;
    dec = in_word;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i > HI) begin
        acc = in_word[i];
      end else if (i >= LO) begin
        acc    = acc ^ in_word[i];
        dec[i] = acc;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    err_d   = err_q;
    if (ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        word_d = dec;
        err_d  = in_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign valid = valid_q;
  assign word  = word_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: rtl/dec_gray2bin.sv
// +--------------------------------------------------------------------------+
// | dec_gray2bin : pipelined gray-to-binary decoder with step checker         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module dec_gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH      = GRAY_W_DEFAULT,
  parameter int STAGES     = 2,
  parameter bit CHECK_STEP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     bin,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;
  logic [STAGES:0]   err;
  logic [WIDTH-1:0]  word [STAGES+1];
  logic              step_bad;
  logic              in_beat;
  logic              out_beat;

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~vld[k] | rdy[k+1];
    end
  end

  assign word[0] = gray;
  assign err[0]  = step_bad;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int HI_K = WIDTH - 1 - k * CHUNK;
      localparam int LO_K = (HI_K - CHUNK + 1 > 0) ? HI_K - CHUNK + 1 : 0;
      dec_gray2bin_stage #(
        .WIDTH (WIDTH),
        .HI    (HI_K),
        .LO    (LO_K)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid ((k == 0) ? in_valid : vld[(k == 0) ? 0 : k-1]),
        .ready    (rdy[k]),
        .in_word  (word[k]),
        .in_err   (err[k]),
        .valid    (vld[k]),
        .word     (word[k+1]),
        .err      (err[k+1])
      );
    end
  endgenerate

  // Ready is held low while reset is asserted even though the stages are empty.
  assign in_ready  = rst_n & rdy[0];
  assign out_valid = vld[STAGES-1];
  assign bin       = word[STAGES];
  assign step_err  = err[STAGES];
  assign in_beat   = in_valid & in_ready;
  assign out_beat  = out_valid & out_ready;

  generate
    if (CHECK_STEP) begin : g_check
      logic [WIDTH-1:0]     prev_q, prev_d;
      logic                 prev_vld_q, prev_vld_d;
      logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

      assign step_bad = prev_vld_q & ~onehot_or_zero(gword_t'(gray ^ prev_q));

      always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        cnt_d      = cnt_q;
        if (in_beat) begin
          prev_d     = gray;
          prev_vld_d = 1'b1;
        end
        if (clr_err) begin
          cnt_d = '0;
        end else if (out_beat && step_err && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q     <= '0;
          prev_vld_q <= 1'b0;
          cnt_q      <= '0;
        end else begin
          prev_q     <= prev_d;
          prev_vld_q <= prev_vld_d;
          cnt_q      <= cnt_d;
        end
      end

      assign err_count = cnt_q;
    end else begin : g_no_check
      assign step_bad  = 1'b0;
      assign err_count = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dec_gray2bin.sv
// Directed bench for dec_gray2bin (WIDTH=10, STAGES=2, CHECK_STEP=1).
`default_nettype none

module tb_dec_gray2bin;
  import gray_pkg::*;

  localparam int W = 10;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic         clr_err   = 1'b0;
  logic [W-1:0] gray      = '0;
  logic         in_ready;
  logic         out_valid;
  logic         step_err;
  logic [W-1:0] bin;
  logic [7:0]   err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_gray2bin #(
    .WIDTH      (W),
    .STAGES     (2),
    .CHECK_STEP (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray      (gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .step_err  (step_err),
    .err_count (err_count),
    .clr_err   (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] eb, input logic ee,
                      input string tag);
    bit got;
    in_valid = 1'b1;
    gray     = g;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (out_valid) got = 1'b1;
      else step();
    end
    chk({tag, "_out_valid"}, got, 1);
    chk({tag, "_bin"}, bin, eb);
    chk({tag, "_step_err"}, step_err, ee);
    step();
  endtask

  initial begin
    gword_t t;
    int     exp_idx;
    int     n;
    logic   inb;
    logic   outb;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bin", bin, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_err_count", err_count, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);

    // Full sweep, back-to-back
    exp_idx = 0;
    for (int i = 0; i < 1028; i++) begin
      in_valid = (i < 1024);
      t        = bin2gray(gword_t'(i));
      gray     = t[W-1:0];
      step();
      if (i == 0) chk("sweep_lat_cyc1", out_valid, 0);
      if (i == 1) chk("sweep_lat_cyc2", out_valid, 1);
      if (out_valid) begin
        chk("sweep_bin", bin, exp_idx);
        chk("sweep_step_err", step_err, 0);
        exp_idx++;
      end
    end
    in_valid = 1'b0;
    chk("sweep_count", exp_idx, 1024);
    chk("sweep_err_count", err_count, 0);

    // Single words
    do_reset();
    send(10'h3FF, 10'h2AA, 1'b0, "single_3ff");
    send(10'h200, 10'h3FF, 1'b1, "single_200");

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gray      = 10'h007;
    #1;
    chk("bp_rdy0", in_ready, 1);
    step();
    gray = 10'h005;
    #1;
    chk("bp_rdy1", in_ready, 1);
    step();
    gray = 10'h004;
    #1;
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_bin_head", bin, 5);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_rdy", in_ready, 0);
      chk("bp_hold_bin", bin, 5);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      #1;
      inb  = in_valid & in_ready;
      outb = out_valid & out_ready;
      if (outb) begin
        chk("bp_order", bin, 5 + n);
        n++;
      end
      step();
      if (inb) in_valid = 1'b0;
    end
    chk("bp_delivered", n, 3);
    chk("bp_in_taken", in_valid, 0);

    // Step errors
    do_reset();
    send(10'h000, 10'h000, 1'b0, "st_000");
    send(10'h001, 10'h001, 1'b0, "st_001");
    send(10'h003, 10'h002, 1'b0, "st_003");
    send(10'h000, 10'h000, 1'b1, "st_000_bad");
    chk("st_err_count", err_count, 1);
    send(10'h001, 10'h001, 1'b0, "st_001b");
    send(10'h003, 10'h002, 1'b0, "st_003b");
    send(10'h003, 10'h002, 1'b0, "st_003_rep");
    chk("st_err_count_rep", err_count, 1);

    // Saturation and clear
    do_reset();
    for (int i = 0; i < 302; i++) begin
      in_valid = 1'b1;
      gray     = i[0] ? 10'h003 : 10'h000;
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("sat_err_count", err_count, 8'hFF);
    in_valid = 1'b1;
    gray     = 10'h000;
    step();
    in_valid = 1'b0;
    step();
    chk("sat_clr_out_valid", out_valid, 1);
    chk("sat_clr_step_err", step_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("sat_clr_err_count", err_count, 0);
    send(10'h003, 10'h002, 1'b1, "sat_next");
    chk("sat_next_err_count", err_count, 1);

    // Reset mid-flight
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gray      = 10'h155;
    step();
    gray = 10'h154;
    step();
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_bin", bin, 0);
    chk("mid_step_err", step_err, 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("mid_rel_out_valid", out_valid, 0);
    step();
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_no_stale", out_valid, 0);
    send(10'h000, 10'h000, 1'b0, "mid_a");
    send(10'h3FF, 10'h2AA, 1'b1, "mid_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
